// File: rtl/crc_result_serializer.sv
// ---------------------------------------------------------------------------
// crc_result_serializer
//
// Output stage of the CRC engine. Captures a finished CRC register value,
// masks it to the configured width, optionally reflects it, applies the final
// XOR and then streams the result one byte at a time over an 8-bit
// valid/ready bus.
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   start        request a new result (only honoured while idle)
//   crc_value    raw CRC register, captured on an accepted start
//   bytewidth    result width in bytes minus one, captured on start
//   reflect_out  reflect the result across its full width
//   xor_out      final XOR constant
//   msb_first    1 = most significant byte first, 0 = bits[7:0] first
//   busy         high from accepted start until the last byte handshake
//   out_byte     current result byte (0 when out_valid is low)
//   out_valid    out_byte is valid
//   out_ready    consumer accepts out_byte
//   out_last     marks the final byte of a result
//   done         one-cycle pulse after the last byte handshake
//
// This file also holds reflect8N, the byte-wise reflector used during the
// FINAL cycle.
// ---------------------------------------------------------------------------

// reflect8N: reflects the low (nbytes_m1_i+1) bytes of data_i as one word.
// Each byte is bit-reversed and the byte order is reversed, which together
// equal a full W-bit reversal. Bytes above the active width come out as 0.
//   data_i       value to reflect
//   nbytes_m1_i  active width in bytes minus one
//   data_o       reflected value
module reflect8N #(
  parameter int MAX_BYTES      = 4,
  parameter int MAX_BYTE_WIDTH = 2
) (
  input  logic [8*MAX_BYTES-1:0]    data_i,
  input  logic [MAX_BYTE_WIDTH-1:0] nbytes_m1_i,
  output logic [8*MAX_BYTES-1:0]    data_o
);

  // Output byte i takes input byte (nb-i) with its bits reversed.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i <= int'(nbytes_m1_i)) begin
        for (int j = 0; j < 8; j++) begin
          data_o[8*i + j] = data_i[8*(int'(nbytes_m1_i) - i) + 7 - j];
        end
      end
    end
  end

endmodule

module crc_result_serializer #(
  parameter int MAX_BITS       = 32,
  parameter int MAX_BYTES      = 4,
  parameter int MAX_BYTE_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [MAX_BITS-1:0]       crc_value,
  input  logic [MAX_BYTE_WIDTH-1:0] bytewidth,
  input  logic                      reflect_out,
  input  logic [MAX_BITS-1:0]       xor_out,
  input  logic                      msb_first,
  output logic                      busy,
  output logic [7:0]                out_byte,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      done
);

  typedef enum logic [1:0] {
    IDLE,
    FINAL,
    SEND
  } state_t;

  state_t                    state_q, state_d;
  logic [MAX_BITS-1:0]       crc_q, crc_d;
  logic [MAX_BITS-1:0]       xor_q, xor_d;
  logic [MAX_BITS-1:0]       res_q, res_d;
  logic [MAX_BYTE_WIDTH-1:0] bw_q, bw_d;
  logic [MAX_BYTE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      refl_q, refl_d;
  logic                      msb_q, msb_d;
  logic                      done_q, done_d;

  logic [MAX_BYTE_WIDTH-1:0] bwClamped;
  logic [MAX_BITS-1:0]       widthMask;
  logic [MAX_BITS-1:0]       maskedCrc;
  logic [MAX_BITS-1:0]       reflectedCrc;
  logic [MAX_BYTE_WIDTH-1:0] byteIdx;

  // Widths beyond the supported maximum fold back to the widest result.
  always_comb begin
    bwClamped = bytewidth;
    if (int'(bytewidth) > MAX_BYTES - 1) begin
      bwClamped = MAX_BYTE_WIDTH'(MAX_BYTES - 1);
    end
  end

  // One mask byte per active result byte; everything at and above W is 0.
  always_comb begin
    widthMask = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      widthMask[8*b +: 8] = (b <= int'(bw_q)) ? 8'hFF : 8'h00;
    end
  end

  assign maskedCrc = crc_q & widthMask;

  reflect8N #(
    .MAX_BYTES      (MAX_BYTES),
    .MAX_BYTE_WIDTH (MAX_BYTE_WIDTH)
  ) u_reflect (
    .data_i      (maskedCrc),
    .nbytes_m1_i (bw_q),
    .data_o      (reflectedCrc)
  );

  // The counter runs from bw down to 0, so in MSB-first order it is the byte
  // index directly; LSB-first walks upward from byte 0.
  assign byteIdx = msb_q ? cnt_q : (bw_q - cnt_q);

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == SEND);
  assign out_last  = (state_q == SEND) && (cnt_q == '0);
  assign out_byte  = (state_q == SEND) ? res_q[8*byteIdx +: 8] : 8'h00;
  assign done      = done_q;

  // State and datapath registers; reset clears everything from any state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      crc_q   <= '0;
      xor_q   <= '0;
      res_q   <= '0;
      bw_q    <= '0;
      cnt_q   <= '0;
      refl_q  <= 1'b0;
      msb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      xor_q   <= xor_d;
      res_q   <= res_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      refl_q  <= refl_d;
      msb_q   <= msb_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Configuration is only captured from IDLE, so a start
  // while busy cannot disturb a result in flight. done is a pure pulse.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    xor_d   = xor_q;
    res_d   = res_q;
    bw_d    = bw_q;
    cnt_d   = cnt_q;
    refl_d  = refl_q;
    msb_d   = msb_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          crc_d   = crc_value;
          xor_d   = xor_out;
          bw_d    = bwClamped;
          refl_d  = reflect_out;
          msb_d   = msb_first;
          state_d = FINAL;
        end
      end

      FINAL: begin
        res_d   = (refl_q ? reflectedCrc : maskedCrc) ^ (xor_q & widthMask);
        cnt_d   = bw_q;
        state_d = SEND;
      end

      SEND: begin
        if (out_ready) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_crc_result_serializer.sv
// ---------------------------------------------------------------------------
// Testbench for crc_result_serializer. Expected bytes are pushed into a
// scoreboard queue as each result is requested; an independent monitor pops
// and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_crc_result_serializer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] crc_value;
  logic [1:0]  bytewidth;
  logic        reflect_out;
  logic [31:0] xor_out;
  logic        msb_first;
  logic        busy;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        done;

  int vecCount;
  int errCount;
  int doneCount;

  // Expected {last, byte} entries.
  logic [8:0] expQ[$];

  crc_result_serializer #(
    .MAX_BITS       (32),
    .MAX_BYTES      (4),
    .MAX_BYTE_WIDTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .crc_value   (crc_value),
    .bytewidth   (bytewidth),
    .reflect_out (reflect_out),
    .xor_out     (xor_out),
    .msb_first   (msb_first),
    .busy        (busy),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [7:0] b, input logic last);
    expQ.push_back({last, b});
  endtask

  // Pulse start for one edge and check the FINAL cycle and first-byte latency.
  task automatic applyStimulus(input logic [31:0] crc, input logic [1:0] bw,
                               input logic refl, input logic [31:0] xo,
                               input logic msb);
    crc_value   = crc;
    bytewidth   = bw;
    reflect_out = refl;
    xor_out     = xo;
    msb_first   = msb;
    start       = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    checkOutput("valid_in_final", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("first_byte_latency", {31'd0, out_valid}, 32'd1);
  endtask

  // Run until the done pulse, then one more cycle for the monitor to see it.
  task automatic waitDone(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      errCount++;
      vecCount++;
      $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", budget);
    end
    tick();
  endtask

  // Monitor: scoreboard on handshakes, backpressure stability, done timing.
  initial begin
    logic       prevStall;
    logic [7:0] prevByte;
    logic       prevLast;
    logic       expDone;
    logic [8:0] e;
    prevStall = 1'b0;
    prevByte  = 8'h00;
    prevLast  = 1'b0;
    expDone   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevStall = 1'b0;
        expDone   = 1'b0;
      end else begin
        if (done) doneCount++;
        if (expDone || done) checkOutput("done_pulse", {31'd0, done}, {31'd0, expDone});
        if (prevStall) begin
          checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
          checkOutput("stall_byte", {24'd0, out_byte}, {24'd0, prevByte});
          checkOutput("stall_last", {31'd0, out_last}, {31'd0, prevLast});
        end
        if (!out_valid) begin
          checkOutput("idle_byte_zero", {24'd0, out_byte}, 32'd0);
        end
        expDone = 1'b0;
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            errCount++;
            vecCount++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no output", out_byte);
          end else begin
            e = expQ.pop_front();
            checkOutput("out_byte", {24'd0, out_byte}, {24'd0, e[7:0]});
            checkOutput("out_last", {31'd0, out_last}, {31'd0, e[8]});
          end
          expDone = out_last;
        end
        prevStall = out_valid && !out_ready;
        prevByte  = out_byte;
        prevLast  = out_last;
      end
    end
  end

  initial begin
    int d0;
    vecCount    = 0;
    errCount    = 0;
    doneCount   = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    crc_value   = '0;
    bytewidth   = '0;
    reflect_out = 1'b0;
    xor_out     = '0;
    msb_first   = 1'b0;
    out_ready   = 1'b1;

    // Reset then idle.
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_last", {31'd0, out_last}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_byte", {24'd0, out_byte}, 32'd0);

    // 32-bit, no reflect, LSB first: 0xCBF43926 ^ 0xFFFFFFFF = 0x340BC6D9.
    pushExp(8'hD9, 1'b0);
    pushExp(8'hC6, 1'b0);
    pushExp(8'h0B, 1'b0);
    pushExp(8'h34, 1'b1);
    d0 = doneCount;
    applyStimulus(32'hCBF43926, 2'd3, 1'b0, 32'hFFFFFFFF, 1'b0);
    waitDone(40);
    checkOutput("crc32_done_count", doneCount - d0, 32'd1);
    checkOutput("crc32_queue_empty", expQ.size(), 32'd0);

    // 16-bit reflect, MSB first: reverse16(0x1234) = 0x2C48.
    pushExp(8'h2C, 1'b0);
    pushExp(8'h48, 1'b1);
    d0 = doneCount;
    applyStimulus(32'h00001234, 2'd1, 1'b1, 32'h00000000, 1'b1);
    waitDone(40);
    checkOutput("refl16_done_count", doneCount - d0, 32'd1);
    checkOutput("refl16_queue_empty", expQ.size(), 32'd0);

    // Masking: 8-bit result, upper crc bits and xor byte 1 drop out.
    pushExp(8'hA5, 1'b1);
    d0 = doneCount;
    applyStimulus(32'hFFFFFFA5, 2'd0, 1'b0, 32'h0000FF00, 1'b0);
    waitDone(40);
    checkOutput("mask8_done_count", doneCount - d0, 32'd1);

    // Backpressure on C6 for three cycles with an ignored start.
    pushExp(8'hD9, 1'b0);
    pushExp(8'hC6, 1'b0);
    pushExp(8'h0B, 1'b0);
    pushExp(8'h34, 1'b1);
    d0 = doneCount;
    applyStimulus(32'hCBF43926, 2'd3, 1'b0, 32'hFFFFFFFF, 1'b0);
    tick();
    checkOutput("bp_byte_c6", {24'd0, out_byte}, 32'h000000C6);
    out_ready = 1'b0;
    tick();
    crc_value = 32'h12345678;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    out_ready = 1'b1;
    waitDone(40);
    tick();
    tick();
    checkOutput("bp_done_count", doneCount - d0, 32'd1);
    checkOutput("bp_no_second_result", {31'd0, busy}, 32'd0);
    checkOutput("bp_queue_empty", expQ.size(), 32'd0);

    // Reset after the second byte handshake, then a fresh full result.
    pushExp(8'hD9, 1'b0);
    pushExp(8'hC6, 1'b0);
    applyStimulus(32'hCBF43926, 2'd3, 1'b0, 32'hFFFFFFFF, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_last", {31'd0, out_last}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_byte", {24'd0, out_byte}, 32'd0);
    checkOutput("midrst_two_popped", expQ.size(), 32'd0);
    expQ.delete();
    rst_n = 1'b1;
    tick();
    pushExp(8'hD9, 1'b0);
    pushExp(8'hC6, 1'b0);
    pushExp(8'h0B, 1'b0);
    pushExp(8'h34, 1'b1);
    d0 = doneCount;
    applyStimulus(32'hCBF43926, 2'd3, 1'b0, 32'hFFFFFFFF, 1'b0);
    waitDone(40);
    checkOutput("postrst_done_count", doneCount - d0, 32'd1);
    checkOutput("postrst_queue_empty", expQ.size(), 32'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
